// File: rtl/jk_ctrl.sv
// jk_ctrl: drives the J/K inputs of an external flip-flop so that it reaches a requested
// next state. It then checks the result and counts failures in a saturating counter.
// Optional build macro: JK_TOGGLE_EN. When it is defined, state changes use the toggle
// excitation (j=k=1) instead of the set/reset excitation.
module jk_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             q,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr
);

    typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic             tgt_q, tgt_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             j_exc, k_exc;

    assign accept    = tgt_valid && (state_q == StIdle);
    assign tgt_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    // The flip-flop has already been clocked with the DRIVE excitation, so q is the result.
    assign err       = (state_q == StCheck) && (q != tgt_q);
    assign j         = j_q;
    assign k         = k_q;
    assign err_cnt   = cnt_q;

    // Excitation table: current q plus requested next state gives the J/K inputs.
    always_comb begin
        j_exc = 1'b0;
        k_exc = 1'b0;
`ifdef JK_TOGGLE_EN
        j_exc = q ^ tgt_bit;
        k_exc = q ^ tgt_bit;
`else
        j_exc = ~q & tgt_bit;
        k_exc = q & ~tgt_bit;
`endif
    end

    // Next-state logic. J/K are loaded only on acceptance, so they are held at 0 elsewhere.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StDrive;
                    tgt_d   = tgt_bit;
                    j_d     = j_exc;
                    k_d     = k_exc;
                end
            end
            StDrive: state_d = StCheck;
            StCheck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // A clear takes priority over a coincident error.
        if (clr) begin
            cnt_d = '0;
        end else if (err && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            tgt_q   <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_jk_ctrl.sv
// tb_jk_ctrl: directed bench for jk_ctrl. It uses a behavioural JK flip-flop that can be
// held stuck. A second instance with CNT_W=2 shares the same inputs so that saturation
// can be checked.
module tb_jk_ctrl;

    logic       clk = 1'b0;
    logic       rstn, tgt_valid, tgt_bit, clr;
    logic       tgt_ready, j, k, busy, err;
    logic [7:0] err_cnt;
    logic       q_ff;
    logic       stuck_en, stuck_val;

    logic       tgt_ready2, j2, k2, busy2, err2;
    logic [1:0] err_cnt2;

    int n_vec = 0;
    int n_err = 0;
    int e8    = 0;
    int e2    = 0;

`ifdef JK_TOGGLE_EN
    localparam logic [1:0] JkSet = 2'b11;
    localparam logic [1:0] JkRst = 2'b11;
`else
    localparam logic [1:0] JkSet = 2'b10;
    localparam logic [1:0] JkRst = 2'b01;
`endif

    always #5 clk = ~clk;

    jk_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .q(q_ff), .j(j), .k(k), .busy(busy), .err(err),
        .err_cnt(err_cnt), .clr(clr)
    );

    jk_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready2), .q(q_ff), .j(j2), .k(k2), .busy(busy2), .err(err2),
        .err_cnt(err_cnt2), .clr(clr)
    );

    // External JK flip-flop model, optionally stuck at a fixed value.
    always @(posedge clk) begin
        if (stuck_en) q_ff <= stuck_val;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(tgt_ready), 32'd1);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_jk"},    32'({j, k}), 32'd0);
        check({tag, "_err"},   32'(err), 32'd0);
    endtask

    // One mismatching target (flip-flop held stuck at 0, target 1). The error is checked
    // in the CHECK cycle and the counters in the following IDLE cycle.
    task automatic stuck_target(input string tag);
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        cyc();
        tgt_valid = 1'b0;
        cyc();
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_err2"}, 32'(err2), 32'd1);
        cyc();
        e8 = e8 + 1;
        e2 = (e2 == 3) ? 3 : e2 + 1;
        check({tag, "_errlo"}, 32'(err), 32'd0);
        check({tag, "_cnt8"}, 32'(err_cnt), 32'(e8));
        check({tag, "_cnt2"}, 32'(err_cnt2), 32'(e2));
    endtask

    initial begin
        rstn = 1'b0; tgt_valid = 1'b0; tgt_bit = 1'b0; clr = 1'b0;
        stuck_en = 1'b1; stuck_val = 1'b0; q_ff = 1'b0;
        cyc(); cyc();
        check_idle("rst");
        check("rst_cnt", 32'(err_cnt), 32'd0);
        check("rst_cnt2", 32'(err_cnt2), 32'd0);
        rstn = 1'b1;
        stuck_en = 1'b0;

        // q=0, target 1
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        cyc();
        check("t1_drv_busy", 32'(busy), 32'd1);
        check("t1_drv_ready", 32'(tgt_ready), 32'd0);
        check("t1_drv_jk", 32'({j, k}), 32'(JkSet));
        tgt_valid = 1'b0;
        cyc();
        check("t1_chk_q", 32'(q_ff), 32'd1);
        check("t1_chk_err", 32'(err), 32'd0);
        check("t1_chk_jk", 32'({j, k}), 32'd0);
        check("t1_chk_busy", 32'(busy), 32'd1);
        cyc();
        check_idle("t1_end");

        // q=1, targets 1 then 0, tgt_valid held throughout
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        cyc();
        check("t2a_drv_jk", 32'({j, k}), 32'd0);
        tgt_bit = 1'b0;
        check("t2a_drv_ready", 32'(tgt_ready), 32'd0);
        cyc();
        check("t2a_chk_ready", 32'(tgt_ready), 32'd0);
        check("t2a_chk_err", 32'(err), 32'd0);
        cyc();
        check("t2b_idle_ready", 32'(tgt_ready), 32'd1);
        cyc();
        check("t2b_drv_jk", 32'({j, k}), 32'(JkRst));
        tgt_valid = 1'b0;
        cyc();
        check("t2b_chk_q", 32'(q_ff), 32'd0);
        check("t2b_chk_err", 32'(err), 32'd0);
        cyc();
        check("t2_cnt", 32'(err_cnt), 32'd0);

        // stuck at 0: three mismatches, then five more to saturate the 2-bit counter
        stuck_en = 1'b1; stuck_val = 1'b0;
        for (int i = 0; i < 3; i++) stuck_target("t3");
        check("t3_cnt_final", 32'(err_cnt), 32'd3);
        for (int i = 0; i < 5; i++) stuck_target("t4");
        check("t4_cnt2_sat", 32'(err_cnt2), 32'd3);
        check("t4_cnt8", 32'(err_cnt), 32'd8);

        // clr in the same cycle as an error
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        cyc();
        tgt_valid = 1'b0;
        cyc();
        check("t5_err", 32'(err), 32'd1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("t5_cnt8", 32'(err_cnt), 32'd0);
        check("t5_cnt2", 32'(err_cnt2), 32'd0);

        // reset during DRIVE
        stuck_en = 1'b0;
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        cyc();
        check("t6_drv_busy", 32'(busy), 32'd1);
        rstn = 1'b0; tgt_valid = 1'b0;
        cyc();
        rstn = 1'b1;
        check_idle("t6_rst");
        cyc();
        check("t6_noerr", 32'(err), 32'd0);
        check("t6_q", 32'(q_ff), 32'd1);
        tgt_valid = 1'b1; tgt_bit = 1'b0;
        cyc();
        check("t6_drv_jk", 32'({j, k}), 32'(JkRst));
        tgt_valid = 1'b0;
        cyc();
        check("t6_chk_q", 32'(q_ff), 32'd0);
        check("t6_chk_err", 32'(err), 32'd0);
        cyc();
        check_idle("t6_end");
        check("t6_cnt", 32'(err_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
